// File: rtl/cache_spi_slave.sv
// SPI mode-0 slave that oversamples SCLK/SS/MOSI on iCLK and exchanges one Nbit MSB-first frame.
// Optional abort reporting on oFrameErr is enabled by defining SPI_FRAMECHK_EN.
//
// state | meaning
// IDLE  | waiting for SS falling edge; SCLK ignored
// SHIFT | frame in progress, shifting on SCLK edges
// DONE  | Nbit bits received; SCLK ignored until SS rises
module cache_spi_slave #(
   parameter int Nbit = 128
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iSCLK,
   input  logic            iSS,
   input  logic            iMOSI,
   output logic            oMISO,
   input  logic [Nbit-1:0] iDATApar,
   output logic [Nbit-1:0] oDATApar,
   output logic            oRXvalid,
   output logic            oBusy,
   output logic            oFrameErr
);

   localparam int CW = $clog2(Nbit + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(Nbit - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state, state_nxt;
   logic            sclk_s1, sclk_s2, sclk_s3;
   logic            ss_s1, ss_s2, ss_s3;
   logic            mosi_s1, mosi_s2;
   logic            sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [CW-1:0]   bit_cnt;
   logic [Nbit-1:0] rx_sr, tx_sr, rx_next;
   logic            load_tx, shift_rx, shift_tx, capture;

   // SS synchronizers clear to 0 so a held-low SS after reset cannot look like a new frame
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         ss_s1   <= 1'b0;
         ss_s2   <= 1'b0;
         ss_s3   <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= iSCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         ss_s1   <= iSS;
         ss_s2   <= ss_s1;
         ss_s3   <= ss_s2;
         mosi_s1 <= iMOSI;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 & sclk_s3;
   assign ss_rise   = ss_s2 & ~ss_s3;
   assign ss_fall   = ~ss_s2 & ss_s3;
   assign rx_next   = {rx_sr[Nbit-2:0], mosi_s2};

`ifdef SPI_FRAMECHK_EN
   logic abort;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_tx   = 1'b0;
      shift_rx  = 1'b0;
      shift_tx  = 1'b0;
      capture   = 1'b0;
`ifdef SPI_FRAMECHK_EN
      abort     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (ss_fall) begin
               load_tx   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // SS release takes priority over a coincident SCLK rise
            if (ss_rise) begin
`ifdef SPI_FRAMECHK_EN
               abort     = 1'b1;
`endif
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               shift_rx = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  capture   = 1'b1;
                  state_nxt = DONE;
               end
            end else if (sclk_fall) begin
               shift_tx = 1'b1;
            end
         end
         DONE: begin
            if (ss_rise) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rx_sr    <= '0;
         tx_sr    <= '0;
         bit_cnt  <= '0;
         oDATApar <= '0;
         oRXvalid <= 1'b0;
         oBusy    <= 1'b0;
      end else begin
         oRXvalid <= capture;
         oBusy    <= (state_nxt != IDLE);
         if (load_tx) begin
            tx_sr   <= iDATApar;
            bit_cnt <= '0;
         end
         if (shift_tx) tx_sr <= {tx_sr[Nbit-2:0], 1'b0};
         if (shift_rx) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (capture) oDATApar <= rx_next;
      end
   end

   assign oMISO = (state != IDLE) & tx_sr[Nbit-1];

`ifdef SPI_FRAMECHK_EN
   logic frame_err;
   always_ff @(posedge iCLK) begin
      if (iRST) frame_err <= 1'b0;
      else      frame_err <= abort;
   end
   assign oFrameErr = frame_err;
`else
   assign oFrameErr = 1'b0;
`endif

endmodule

// File: tb/tb_cache_spi_slave.sv
// Directed bench for cache_spi_slave: table of frames plus reset corner sequences.
module tb_cache_spi_slave;

   localparam int N = 128;

   logic         iCLK, iRST, iSCLK, iSS, iMOSI;
   logic         oMISO, oRXvalid, oBusy, oFrameErr;
   logic [N-1:0] iDATApar, oDATApar;

   cache_spi_slave #(.Nbit(N)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSCLK(iSCLK), .iSS(iSS), .iMOSI(iMOSI),
      .oMISO(oMISO), .iDATApar(iDATApar), .oDATApar(oDATApar),
      .oRXvalid(oRXvalid), .oBusy(oBusy), .oFrameErr(oFrameErr)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int cyc = 0;
   int rx_cnt = 0;
   int rx_cyc = -1;
   int fe_cnt = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   always @(negedge iCLK) begin
      if (oRXvalid === 1'b1) begin
         rx_cnt = rx_cnt + 1;
         rx_cyc = cyc;
      end
      if (oFrameErr === 1'b1) fe_cnt = fe_cnt + 1;
   end

   typedef struct {
      logic [N-1:0] mosi;
      logic [N-1:0] par;
      int           rises;
      bit           chg;
      int           exp_valid;
      logic [N-1:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   task automatic tick(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One SS-framed transfer, SCLK half period of 4 iCLK; master samples MISO just before each rise
   task automatic run_frame(input logic [N-1:0] mosi, input logic [N-1:0] par,
                            input int rises, input bit chg, input int rst_at,
                            output logic [N-1:0] miso_w, output logic [N-1:0] mask,
                            output bit extra_bad, output int lat);
      int rise_cyc;
      rise_cyc  = -1;
      miso_w    = '0;
      mask      = '0;
      extra_bad = 1'b0;
      lat       = -1;
      rx_cnt    = 0;
      rx_cyc    = -1;
      fe_cnt    = 0;
      iDATApar  = par;
      iMOSI     = 1'b0;
      iSS       = 1'b0;
      tick(3);
      check("miso_first_bit", {{(N-1){1'b0}}, oMISO}, {{(N-1){1'b0}}, par[N-1]});
      check("busy_on", {{(N-1){1'b0}}, oBusy}, {{(N-1){1'b0}}, 1'b1});
      tick(1);
      for (int k = 0; k < rises; k++) begin
         if (k == rst_at) begin
            iRST = 1'b1;
            tick(2);
            iRST = 1'b0;
            tick(1);
            check("busy_after_reset", {{(N-1){1'b0}}, oBusy}, '0);
         end
         iMOSI = (k < N) ? mosi[N-1-k] : 1'b1;
         if (chg && k == 10) iDATApar = ~par;
         tick(4);
         if (k < N) begin
            if (rst_at < 0 || k < rst_at) begin
               miso_w[N-1-k] = oMISO;
               mask[N-1-k]   = 1'b1;
            end
         end else if (oMISO !== par[0]) begin
            extra_bad = 1'b1;
         end
         iSCLK = 1'b1;
         if (k == N - 1) rise_cyc = cyc;
         tick(4);
         iSCLK = 1'b0;
      end
      tick(4);
      iSS = 1'b1;
      tick(8);
      check("busy_off", {{(N-1){1'b0}}, oBusy}, '0);
      if (rise_cyc >= 0 && rx_cyc >= rise_cyc) lat = rx_cyc - rise_cyc;
   endtask

   initial begin
      logic [N-1:0] miso_w, mask;
      bit           extra_bad;
      int           lat, exp_fe;

      vecs[0] = '{128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, {16{8'hA5}}, 128, 1'b0, 1,
                  128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C};
      vecs[1] = '{128'h13579BDF_2468ACE0_FFFFFFFF_00000000, {16{8'h5A}}, 37, 1'b0, 0,
                  128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C};
      vecs[2] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'hC3C3C3C3_12345678_00000000_0000003D, 130, 1'b0, 1,
                  128'h01234567_89ABCDEF_FEDCBA98_76543210};
      vecs[3] = '{128'hCAFEF00D_11223344_55667788_99AABBCC, 128'h0F0F0F0F_F0F0F0F0_33333333_CCCCCCCC, 128, 1'b1, 1,
                  128'hCAFEF00D_11223344_55667788_99AABBCC};
      vecs[4] = '{128'h80000000_00000000_00000000_00000001, 128'hFFFF0000_FFFF0000_12345678_9ABCDEF0, 128, 1'b0, 1,
                  128'h80000000_00000000_00000000_00000001};

      // Reset with SS low and SCLK toggling
      iRST = 1'b1; iSS = 1'b0; iSCLK = 1'b0; iMOSI = 1'b1; iDATApar = {16{8'hFF}};
      for (int i = 0; i < 6; i++) begin
         tick(2); iSCLK = ~iSCLK;
      end
      check("rst_data", oDATApar, '0);
      check("rst_valid", {{(N-1){1'b0}}, oRXvalid}, '0);
      check("rst_miso", {{(N-1){1'b0}}, oMISO}, '0);
      check("rst_busy", {{(N-1){1'b0}}, oBusy}, '0);
      check("rst_frameerr", {{(N-1){1'b0}}, oFrameErr}, '0);
      iRST = 1'b0;
      rx_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick(3); iSCLK = ~iSCLK;
      end
      check("held_ss_no_busy", {{(N-1){1'b0}}, oBusy}, '0);
      check("held_ss_no_valid", N'(rx_cnt), '0);
      iSCLK = 1'b0; iSS = 1'b1;
      tick(8);

      for (int v = 0; v < 5; v++) begin
         run_frame(vecs[v].mosi, vecs[v].par, vecs[v].rises, vecs[v].chg, -1,
                   miso_w, mask, extra_bad, lat);
`ifdef SPI_FRAMECHK_EN
         exp_fe = (vecs[v].rises < N) ? 1 : 0;
`else
         exp_fe = 0;
`endif
         check($sformatf("v%0d_valid_count", v), N'(rx_cnt), N'(vecs[v].exp_valid));
         check($sformatf("v%0d_data", v), oDATApar, vecs[v].exp_data);
         check($sformatf("v%0d_miso", v), miso_w & mask, vecs[v].par & mask);
         check($sformatf("v%0d_frameerr", v), N'(fe_cnt), N'(exp_fe));
         if (vecs[v].exp_valid != 0) check($sformatf("v%0d_latency", v), N'(lat), N'(3));
         if (vecs[v].rises > N) check($sformatf("v%0d_miso_hold", v), {{(N-1){1'b0}}, extra_bad}, '0);
      end

      // Reset at bit 60 with SS held low, SCLK keeps running to the end of the frame
      run_frame(128'hFEEDFACE_DEADC0DE_0BADF00D_8BADF00D, {16{8'h69}}, 128, 1'b0, 60,
                miso_w, mask, extra_bad, lat);
      check("rst_mid_no_valid", N'(rx_cnt), '0);
      check("rst_mid_data_cleared", oDATApar, '0);
      check("rst_mid_frameerr", N'(fe_cnt), '0);
      check("rst_mid_miso_pre", miso_w & mask, {16{8'h69}} & mask);

      run_frame(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 128, 1'b0, -1,
                miso_w, mask, extra_bad, lat);
      check("post_rst_valid", N'(rx_cnt), N'(1));
      check("post_rst_data", oDATApar, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
      check("post_rst_miso", miso_w, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      check("post_rst_latency", N'(lat), N'(3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
